flex_updown_counter: RTL

Parametrised up/down flex counter. Supports synchronous load, a programmable terminal value, and wrap or saturate modes. Provides registered terminal-count flags, a one-cycle wrap pulse and a saturating wrap-event counter. Used by timing/control FSMs (bit-period timers, byte counters, retry counters) that need both count directions and wrap accounting.

---
 rtl/flex_counter_pkg.sv | 14 +
 rtl/flex_updown_counter_if.sv | 32 +++
 rtl/flex_updown_counter_sat_event_counter.sv | 38 +++
 rtl/flex_updown_counter.sv | 101 ++++++++++
 4 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types and constants for the flex up/down counter.
package flex_counter_pkg;

  // Behaviour when the count reaches either end of its 1..rollover_val range.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_t;

  // Count direction encodings.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : flex_counter_pkg

// File: rtl/flex_updown_counter_if.sv
// Control/status bundle between a controlling FSM (master) and the counter (slave).
interface flex_updown_counter_if #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int WRAP_CNT_BITS = 8
);
  import flex_counter_pkg::*;

  logic                     clear;
  logic                     load;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic                     count_enable;
  logic                     count_dir;
  cnt_mode_t                mode;
  logic [NUM_CNT_BITS-1:0]  rollover_val;

  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     rollover_flag;
  logic                     rollunder_flag;
  logic                     wrap_pulse;
  logic [WRAP_CNT_BITS-1:0] wrap_cnt;

  modport master (
    output clear, load, load_val, count_enable, count_dir, mode, rollover_val,
    input  count_out, rollover_flag, rollunder_flag, wrap_pulse, wrap_cnt
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_dir, mode, rollover_val,
    output count_out, rollover_flag, rollunder_flag, wrap_pulse, wrap_cnt
  );

endinterface : flex_updown_counter_if

// File: rtl/flex_updown_counter_sat_event_counter.sv
// Saturating event counter: clears on clr_i, increments on inc_i, sticks at all-ones.
module sat_event_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next value: clear wins, otherwise increment unless already saturated.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Event count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so all registers sample pre-edge values together.
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_event_counter

// File: rtl/flex_updown_counter.sv
// Parametrised up/down flex counter with load, programmable terminal value,
// wrap/saturate modes, registered terminal flags and wrap accounting.
module flex_updown_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS  = 4,
  parameter int WRAP_CNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  flex_updown_counter_if.slave  bus
);

  // One extra bit keeps +1 at all-ones from aliasing back to zero.
  localparam int EXT = NUM_CNT_BITS + 1;

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;
  logic                    rollover_q;
  logic                    rollover_d;
  logic                    rollunder_q;
  logic                    rollunder_d;
  logic                    wrap_pulse_q;
  logic                    wrap_pulse_d;

  logic [EXT-1:0]          cnt_ext;
  logic [EXT-1:0]          roll_ext;
  logic [EXT-1:0]          next_ext;
  logic                    roll_nz;
  logic                    wrap_evt;

  assign cnt_ext  = {1'b0, count_q};
  assign roll_ext = {1'b0, bus.rollover_val};
  assign roll_nz  = (bus.rollover_val != '0);

  // Next count and wrap event; priority clear > load > enable > hold.
  always_comb begin
    next_ext = cnt_ext;
    wrap_evt = 1'b0;
    if (bus.clear) begin
      next_ext = '0;
    end else if (bus.load) begin
      next_ext = {1'b0, bus.load_val};
    end else if (bus.count_enable && roll_nz) begin
      if (bus.count_dir == DIR_UP) begin
        if (cnt_ext < roll_ext) begin
          next_ext = cnt_ext + EXT'(1);
        end else if (bus.mode == MODE_WRAP) begin
          next_ext = EXT'(1);
          wrap_evt = 1'b1;
        end
      end else begin
        if (cnt_ext > EXT'(1)) begin
          next_ext = cnt_ext - EXT'(1);
        end else if (bus.mode == MODE_WRAP) begin
          next_ext = roll_ext;
          wrap_evt = 1'b1;
        end
      end
    end
  end

  // Flags look at the next count so they line up with count_out after the edge.
  always_comb begin
    count_d      = next_ext[NUM_CNT_BITS-1:0];
    rollover_d   = roll_nz && (next_ext == roll_ext);
    rollunder_d  = roll_nz && (next_ext == EXT'(1));
    wrap_pulse_d = wrap_evt;
  end

  // Count, flag and pulse registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q      <= '0;
      rollover_q   <= 1'b0;
      rollunder_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      rollover_q   <= rollover_d;
      rollunder_q  <= rollunder_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  sat_event_counter #(
    .WIDTH (WRAP_CNT_BITS)
  ) u_wrap_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (bus.clear),
    .inc_i (wrap_evt),
    .cnt_o (bus.wrap_cnt)
  );

  assign bus.count_out      = count_q;
  assign bus.rollover_flag  = rollover_q;
  assign bus.rollunder_flag = rollunder_q;
  assign bus.wrap_pulse     = wrap_pulse_q;

endmodule : flex_updown_counter
